key_input_conditioner: RTL and testbench
========================================

KEY_INPUT_CONDITIONER -- requirements
Module: key_input_conditioner

Interface
REQ-001 Parameter: DB_CYCLES, default 2000000, consecutive cycles a synchronized input must differ from its stable value before the stable value changes; legal range 1 to 2^24-1.
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous assertion, active-low (0 = reset).
REQ-004 Port: key_raw  input  [0:7]  raw piano key switches, 1 = pressed, asynchronous to clk, index 0 = lowest note.
REQ-005 Port: mode_raw  input  1  raw mode button, 1 = pressed, asynchronous to clk.
REQ-006 Port: key_board  output  [0:7]  debounced key levels, same bit order as key_raw; drives the mode FSM keyboard input directly.
REQ-007 Port: key_press  output  [0:7]  one-cycle pulse per key on debounced 0->1.
REQ-008 Port: note_code  output  3  index of the lowest-numbered key currently set in key_board.
REQ-009 Port: note_valid  output  1  1 when any bit of key_board is 1.
REQ-010 Port: mode_pulse  output  1  one-cycle pulse on debounced 0->1 of mode_raw.

Function
REQ-011 Each of the 9 raw inputs SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each input SHALL have an independent debouncer: a 1-bit stable register and a counter at least ceil(log2(DB_CYCLES+1)) bits wide.
REQ-013 Debouncer states: IDLE (synced == stable, counter = 0) and COUNT (synced != stable, counter incrementing once per cycle).
REQ-014 Any cycle with synced == stable SHALL force IDLE and clear the counter, with no change to stable.
REQ-015 When synced != stable on DB_CYCLES consecutive cycles, stable SHALL toggle on the clock edge ending the DB_CYCLES-th such cycle; the counter clears and the debouncer returns to IDLE.
REQ-016 Latency from a clean raw edge to the key_board or internal mode level change SHALL be exactly 2 + DB_CYCLES cycles, with a tolerance of +1 cycle for input sampling phase.
REQ-017 A raw pulse or glitch shorter than DB_CYCLES synchronized cycles SHALL produce no output change.
REQ-018 The counter SHALL never wrap; it saturates at DB_CYCLES.
REQ-019 key_board[i] SHALL equal stable[i] directly, with no extra register stage.
REQ-020 key_press[i] SHALL be 1 for exactly one cycle, the first cycle in which key_board[i] is 1; it SHALL NOT repeat while the key is held, and SHALL NOT pulse on release.
REQ-021 mode_pulse SHALL follow the same rule as key_press, applied to the debounced mode level.
REQ-022 note_code / note_valid SHALL be combinational from key_board with zero added latency.
REQ-023 With several keys set, note_code SHALL be the lowest set index.
REQ-024 With no key set, note_code SHALL be 3'd0 and note_valid SHALL be 0.
REQ-025 Keys debounced in the same cycle SHALL pulse their key_press bits in the same cycle, independently.
REQ-026 A key release and a different key press in the same cycle SHALL update both bits in that cycle; note_code reflects the new set.

Reset
REQ-027 While rst = 0, all synchronizer flops, stable registers and counters SHALL be 0.
REQ-028 While rst = 0, all outputs SHALL be 0: key_board = 8'h00, key_press = 8'h00, note_code = 0, note_valid = 0, mode_pulse = 0.
REQ-029 Reset asserted mid-count SHALL abort the count.
REQ-030 After reset release, a key held throughout reset SHALL be treated as a new press: key_press pulses 2 + DB_CYCLES cycles after release.
REQ-031 Reset release SHALL be synchronous to clk at the system level; this block adds no reset synchronizer.

Verification (bench DB_CYCLES = 4)
REQ-032 key_raw[3] 0->1 held -> key_board[3] = 1 after 6 cycles (+1 max); key_press = 8'h10 for one cycle; note_code = 3, note_valid = 1.
REQ-033 key_raw[5] high for 3 cycles, then low -> key_board, key_press and note_valid stay 0 throughout.
REQ-034 key_raw[1] and key_raw[6] rise in the same cycle -> both key_press bits pulse in the same cycle; note_code = 1; release key 1 only -> note_code = 6 after debounce.
REQ-035 mode_raw held high for 20 cycles -> exactly one mode_pulse; release -> no pulse.
REQ-036 rst = 0 at cycle 3 of a key_raw[0] count, key_raw[0] kept high -> outputs 0 during reset; after release, key_press[0] pulses once at 6 to 7 cycles.
REQ-037 key_raw[2] toggled every 2 cycles for 40 cycles -> key_board[2] never changes.

Source files
------------

// File: rtl/key_input_conditioner.sv
// Piano key / mode button front end: per-input 2-flop sync, saturating debounce,
// rising-edge pulses and a lowest-key priority encoder for the note path.

module key_db_lane #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int          CW        = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);
    logic [1:0]    sync_q;
    logic          stable_q, stable_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while synced differs from stable (COUNT); any agreeing
    // cycle drops back to IDLE with the counter cleared.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q >= CW'(DB_CYCLES - 1)) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], raw_i};
            stable_q <= stable_d;
            prev_q   <= stable_q;
            cnt_q    <= cnt_d;
        end
    end

    assign level_o = stable_q;
    assign rise_o  = stable_q & ~prev_q;
endmodule

module key_input_conditioner #(
    parameter int unsigned DB_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:7] key_raw,
    input  logic       mode_raw,
    output logic [0:7] key_board,
    output logic [0:7] key_press,
    output logic [2:0] note_code,
    output logic       note_valid,
    output logic       mode_pulse
);
    localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);

    logic mode_level;

    generate
        for (genvar i = 0; i < 8; i++) begin : g_key
            key_db_lane #(.DB_CYCLES(DB_CYCLES), .CW(CW)) u_lane (
                .clk     (clk),
                .rst     (rst),
                .raw_i   (key_raw[i]),
                .level_o (key_board[i]),
                .rise_o  (key_press[i])
            );
        end
    endgenerate

    key_db_lane #(.DB_CYCLES(DB_CYCLES), .CW(CW)) u_mode (
        .clk     (clk),
        .rst     (rst),
        .raw_i   (mode_raw),
        .level_o (mode_level),
        .rise_o  (mode_pulse)
    );

    // Scan high to low so the lowest set key wins.
    always_comb begin
        note_code = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (key_board[i]) note_code = 3'(i);
        end
        note_valid = |key_board;
    end

    logic unused_mode_level;
    assign unused_mode_level = mode_level;
endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with DB_CYCLES = 4 (6-cycle edge latency).

module tb_key_input_conditioner;
    logic       clk = 1'b0;
    logic       rst;
    logic [0:7] key_raw;
    logic       mode_raw;
    logic [0:7] key_board;
    logic [0:7] key_press;
    logic [2:0] note_code;
    logic       note_valid;
    logic       mode_pulse;

    int passed = 0;
    int total  = 0;

    key_input_conditioner #(.DB_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_raw    (key_raw),
        .mode_raw   (mode_raw),
        .key_board  (key_board),
        .key_press  (key_press),
        .note_code  (note_code),
        .note_valid (note_valid),
        .mode_pulse (mode_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        key_raw  = 8'hFF;
        mode_raw = 1'b1;
        tick(3);
        total++;
        if ({key_board, key_press, note_code, note_valid, mode_pulse} !== 21'd0)
            $display("FAIL reset_outputs: got %h %h %0d %b %b, want all 0",
                     key_board, key_press, note_code, note_valid, mode_pulse);
        else passed++;
        key_raw  = 8'h00;
        mode_raw = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(8);
        total++;
        if ({key_board, key_press, note_valid, mode_pulse} !== 18'd0)
            $display("FAIL reset_release_idle: got board=%h press=%h", key_board, key_press);
        else passed++;
    endtask

    task automatic test_single_key();
        key_raw[3] = 1'b1;
        tick(5);
        total++;
        if (key_board !== 8'h00) $display("FAIL single_early: board=%h want 00", key_board);
        else passed++;
        tick(1);
        total++;
        if (key_board !== 8'h10 || key_press !== 8'h10)
            $display("FAIL single_press: board=%h press=%h want 10 10", key_board, key_press);
        else passed++;
        total++;
        if (note_code !== 3'd3 || note_valid !== 1'b1)
            $display("FAIL single_note: code=%0d valid=%b want 3 1", note_code, note_valid);
        else passed++;
        tick(1);
        total++;
        if (key_board !== 8'h10 || key_press !== 8'h00)
            $display("FAIL single_hold: board=%h press=%h want 10 00", key_board, key_press);
        else passed++;
        key_raw[3] = 1'b0;
        begin
            int pulses = 0;
            for (int n = 0; n < 8; n++) begin
                tick(1);
                if (key_press !== 8'h00) pulses++;
            end
            total++;
            if (pulses !== 0 || key_board !== 8'h00 || note_valid !== 1'b0)
                $display("FAIL single_release: pulses=%0d board=%h valid=%b want 0 00 0",
                         pulses, key_board, note_valid);
            else passed++;
        end
    endtask

    task automatic test_glitch();
        int changes = 0;
        key_raw[5] = 1'b1;
        tick(3);
        key_raw[5] = 1'b0;
        for (int n = 0; n < 12; n++) begin
            if (key_board !== 8'h00 || key_press !== 8'h00 || note_valid !== 1'b0) changes++;
            tick(1);
        end
        total++;
        if (changes !== 0) $display("FAIL glitch_key5: %0d disturbed cycles, want 0", changes);
        else passed++;
    endtask

    task automatic test_two_keys();
        key_raw[1] = 1'b1;
        key_raw[6] = 1'b1;
        tick(6);
        total++;
        if (key_press !== 8'h42 || key_board !== 8'h42)
            $display("FAIL two_press: press=%h board=%h want 42 42", key_press, key_board);
        else passed++;
        total++;
        if (note_code !== 3'd1) $display("FAIL two_note: code=%0d want 1", note_code);
        else passed++;
        key_raw[1] = 1'b0;
        tick(6);
        total++;
        if (key_board !== 8'h02 || note_code !== 3'd6 || key_press !== 8'h00)
            $display("FAIL two_release1: board=%h code=%0d press=%h want 02 6 00",
                     key_board, note_code, key_press);
        else passed++;
    endtask

    task automatic test_back_to_back();
        // key 6 still held from the previous scenario
        key_raw[6] = 1'b0;
        key_raw[4] = 1'b1;
        tick(5);
        total++;
        if (key_board !== 8'h02) $display("FAIL swap_early: board=%h want 02", key_board);
        else passed++;
        tick(1);
        total++;
        if (key_board !== 8'h08 || key_press !== 8'h08 || note_code !== 3'd4)
            $display("FAIL swap: board=%h press=%h code=%0d want 08 08 4",
                     key_board, key_press, note_code);
        else passed++;
        key_raw[4] = 1'b0;
        tick(8);
        total++;
        if (key_board !== 8'h00 || note_code !== 3'd0 || note_valid !== 1'b0)
            $display("FAIL swap_clear: board=%h code=%0d valid=%b want 00 0 0",
                     key_board, note_code, note_valid);
        else passed++;
    endtask

    task automatic test_mode();
        int pulses = 0;
        mode_raw = 1'b1;
        for (int n = 0; n < 20; n++) begin
            tick(1);
            if (mode_pulse === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 1) $display("FAIL mode_hold: pulses=%0d want 1", pulses);
        else passed++;
        pulses = 0;
        mode_raw = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick(1);
            if (mode_pulse === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0) $display("FAIL mode_release: pulses=%0d want 0", pulses);
        else passed++;
    endtask

    task automatic test_reset_mid_count();
        int first = 0;
        int pulses = 0;
        key_raw[0] = 1'b1;
        tick(3);
        rst = 1'b0;
        #1;
        total++;
        if ({key_board, key_press, note_code, note_valid, mode_pulse} !== 21'd0)
            $display("FAIL midreset_out: board=%h press=%h want 00 00", key_board, key_press);
        else passed++;
        tick(3);
        total++;
        if (key_board !== 8'h00 || key_press !== 8'h00)
            $display("FAIL midreset_hold: board=%h press=%h want 00 00", key_board, key_press);
        else passed++;
        rst = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick(1);
            if (key_press[0] === 1'b1) begin
                pulses++;
                if (first == 0) first = n;
            end
        end
        total++;
        if (first < 6 || first > 7)
            $display("FAIL midreset_latency: first pulse at %0d want 6..7", first);
        else passed++;
        total++;
        if (pulses !== 1 || key_board !== 8'h80)
            $display("FAIL midreset_once: pulses=%0d board=%h want 1 80", pulses, key_board);
        else passed++;
        key_raw[0] = 1'b0;
        tick(8);
    endtask

    task automatic test_chatter();
        int changes = 0;
        for (int n = 0; n < 40; n++) begin
            if (n % 2 == 0) key_raw[2] = ~key_raw[2];
            tick(1);
            if (key_board[2] !== 1'b0 || key_press[2] !== 1'b0) changes++;
        end
        key_raw[2] = 1'b0;
        tick(8);
        total++;
        if (changes !== 0 || key_board !== 8'h00)
            $display("FAIL chatter_key2: changes=%0d board=%h want 0 00", changes, key_board);
        else passed++;
    endtask

    initial begin
        rst      = 1'b0;
        key_raw  = 8'h00;
        mode_raw = 1'b0;
        test_reset();
        test_single_key();
        test_glitch();
        test_two_keys();
        test_back_to_back();
        test_mode();
        test_reset_mid_count();
        test_chatter();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
